// File: rtl/mem_ctrl.sv
// Single-port RAM controller: accepts one CPU request at a time and sequences the RAM strobes.
// Optional write read-back check is enabled by defining MEM_CTRL_WRVERIFY_EN.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] BusMuxOut,
  input  logic [DATA_W-1:0] MDataIn
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
`ifdef MEM_CTRL_WRVERIFY_EN
    VRD  = 3'd5,
    VCAP = 3'd6,
`endif
    RSP  = 3'd4
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   accept_s;
  logic   write_r;

  // Next-state decode; a strobe state that disagrees with the latched direction falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s     = 1'b1;
          next_state_s = req_write ? WR : RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      WR: begin
        if (write_r) begin
`ifdef MEM_CTRL_WRVERIFY_EN
          next_state_s = VRD;
`else
          next_state_s = RSP;
`endif
        end else begin
          next_state_s = IDLE;
        end
      end
      RD: begin
        if (write_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = CAP;
        end
      end
      CAP: next_state_s = RSP;
`ifdef MEM_CTRL_WRVERIFY_EN
      VRD:  next_state_s = VCAP;
      VCAP: next_state_s = RSP;
`endif
      RSP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RSP;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register, registered handshake/strobe outputs and request datapath.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      BusMuxOut <= {DATA_W{1'b0}};
      rsp_rdata <= {DATA_W{1'b0}};
      write_r   <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      req_ready <= (next_state_s == IDLE);
      rsp_valid <= (next_state_s == RSP);
      mem_write <= (next_state_s == WR);
`ifdef MEM_CTRL_WRVERIFY_EN
      mem_read  <= (next_state_s == RD) || (next_state_s == VRD);
`else
      mem_read  <= (next_state_s == RD);
`endif
      if (accept_s) begin
        mem_addr  <= req_addr;
        BusMuxOut <= req_wdata;
        write_r   <= req_write;
      end
      // MDataIn is valid during CAP/VCAP, one cycle after the read strobe was sampled.
      if (state_r == CAP) begin
        rsp_rdata <= MDataIn;
      end
`ifdef MEM_CTRL_WRVERIFY_EN
      if (state_r == VCAP) begin
        rsp_rdata <= MDataIn;
      end
`endif
    end
  end

`ifdef MEM_CTRL_WRVERIFY_EN
  // Read-back compare flag, refreshed with every response and held in between.
  always_ff @(posedge clock) begin
    if (clear) begin
      rsp_err <= 1'b0;
    end else if (state_r == VCAP) begin
      rsp_err <= (MDataIn != BusMuxOut);
    end else if (state_r == CAP) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a behavioural RAM device plus an address->data reference map.
module tb_mem_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
`ifdef MEM_CTRL_WRVERIFY_EN
  localparam int WR_LAT = 4;
  localparam int WR_RDS = 1;
`else
  localparam int WR_LAT = 2;
  localparam int WR_RDS = 0;
`endif
  localparam int RD_LAT = 3;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] BusMuxOut;
  logic [DW-1:0] MDataIn = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int both_hi = 0;
  bit fault_en = 1'b0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [int];
  int written[$];

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .BusMuxOut(BusMuxOut), .MDataIn(MDataIn)
  );

  always #5 clock = ~clock;

  // RAM device: synchronous write, read data valid the cycle after the sampled strobe.
  always @(posedge clock) begin
    if (mem_write === 1'b1) ram[mem_addr] <= BusMuxOut;
    if (mem_read === 1'b1) MDataIn <= fault_en ? (ram[mem_addr] ^ 32'h1) : ram[mem_addr];
  end

  always @(negedge clock) begin
    if (mem_read === 1'b1 && mem_write === 1'b1) both_hi++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Issue one request with rsp_ready=1; starts and ends at a negedge with the DUT idle.
  task automatic txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rd, output logic er, output int lat,
                     output int nwr, output int nrd, output int nbad_addr);
    nwr = 0; nrd = 0; nbad_addr = 0; lat = 1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      if (mem_write === 1'b1) begin nwr++; if (mem_addr !== a) nbad_addr++; end
      if (mem_read === 1'b1) begin nrd++; if (mem_addr !== a) nbad_addr++; end
      @(posedge clock); lat++; @(negedge clock);
    end
    rd = rsp_rdata; er = rsp_err;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = AW'($urandom);
    req_wdata = $urandom; rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_cmp++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    n_cmp++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    n_cmp++; if (mem_addr !== 9'h000) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    n_cmp++; if (BusMuxOut !== 32'h0) begin n_bad++; $display("FAIL reset_busmuxout: got %h want 0", BusMuxOut); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    req_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; logic er; int lat, nwr, nrd, nba;
    txn(1'b1, 9'h005, 32'hDEADBEEF, rd, er, lat, nwr, nrd, nba);
    ref_mem[5] = 32'hDEADBEEF; written.push_back(5);
    n_cmp++; if (lat != WR_LAT) begin n_bad++; $display("FAIL wr_latency: got %0d want %0d", lat, WR_LAT); end
    n_cmp++; if (nwr != 1) begin n_bad++; $display("FAIL wr_strobe_cycles: got %0d want 1", nwr); end
    n_cmp++; if (nrd != WR_RDS) begin n_bad++; $display("FAIL wr_read_strobes: got %0d want %0d", nrd, WR_RDS); end
    n_cmp++; if (nba != 0) begin n_bad++; $display("FAIL wr_strobe_addr: got %0d bad want 0", nba); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b want 0", er); end
    n_cmp++; if (BusMuxOut !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_busmuxout_hold: got %h want deadbeef", BusMuxOut); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_back_to_idle: got %b want 1", req_ready); end
    txn(1'b0, 9'h005, $urandom, rd, er, lat, nwr, nrd, nba);
    n_cmp++; if (lat != RD_LAT) begin n_bad++; $display("FAIL rd_latency: got %0d want %0d", lat, RD_LAT); end
    n_cmp++; if (rd !== ref_mem[5]) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd, ref_mem[5]); end
    n_cmp++; if (nrd != 1 || nwr != 0 || nba != 0) begin n_bad++; $display("FAIL rd_strobes: got rd=%0d wr=%0d badaddr=%0d want 1/0/0", nrd, nwr, nba); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] rd, d; logic er; int lat, nwr, nrd, nba, pa;
    d = $urandom;
    txn(1'b1, 9'h01F, d, rd, er, lat, nwr, nrd, nba);
    ref_mem[31] = d; written.push_back(31);
    pa = written[0];
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h01F; rsp_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clock); lat++; @(negedge clock); end
    n_cmp++; if (lat != RD_LAT) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, RD_LAT); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(pa); req_wdata = ~ref_mem[pa];
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clock); @(negedge clock);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d || req_ready !== 1'b0 || mem_addr !== 9'h01F || mem_write !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got valid=%b rdata=%h ready=%b addr=%h wr=%b want 1/%h/0/01f/0",
                 i, rsp_valid, rsp_rdata, req_ready, mem_addr, mem_write, d);
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    txn(1'b0, AW'(pa), $urandom, rd, er, lat, nwr, nrd, nba);
    n_cmp++; if (rd !== ref_mem[pa]) begin n_bad++; $display("FAIL bp_pulse_ignored: got %h want %h", rd, ref_mem[pa]); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd; logic er; int lat, nwr, nrd, nba, a; bit saw;
    a = written[$urandom_range(0, written.size() - 1)];
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a); rsp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL mid_in_rd: got mem_read=%b want 1", mem_read); end
    clear = 1'b1;
    @(posedge clock); @(negedge clock);
    clear = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || mem_read !== 1'b0 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_clear_idle: got ready=%b rd=%b valid=%b want 1/0/0", req_ready, mem_read, rsp_valid); end
    n_cmp++; if (mem_addr !== 9'h000 || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_clear_data: got addr=%h rdata=%h want 000/0", mem_addr, rsp_rdata); end
    saw = 1'b0;
    repeat (6) begin @(posedge clock); @(negedge clock); if (rsp_valid !== 1'b0) saw = 1'b1; end
    n_cmp++; if (saw) begin n_bad++; $display("FAIL mid_no_response: got rsp_valid seen want none"); end
    txn(1'b0, AW'(a), $urandom, rd, er, lat, nwr, nrd, nba);
    n_cmp++; if (rd !== ref_mem[a] || lat != RD_LAT) begin n_bad++; $display("FAIL mid_recover: got %h lat %0d want %h lat %0d", rd, lat, ref_mem[a], RD_LAT); end
  endtask

`ifdef MEM_CTRL_WRVERIFY_EN
  task automatic test_write_verify();
    logic [DW-1:0] rd; logic er; int lat, nwr, nrd, nba;
    txn(1'b1, 9'h010, 32'h00000053, rd, er, lat, nwr, nrd, nba);
    ref_mem[16] = 32'h00000053; written.push_back(16);
    n_cmp++; if (er !== 1'b0 || lat != 4) begin n_bad++; $display("FAIL wv_good: got err=%b lat=%0d want 0/4", er, lat); end
    fault_en = 1'b1;
    txn(1'b1, 9'h010, 32'h00000053, rd, er, lat, nwr, nrd, nba);
    fault_en = 1'b0;
    n_cmp++; if (er !== 1'b1 || rd !== 32'h00000052) begin n_bad++; $display("FAIL wv_fault: got err=%b rdata=%h want 1/00000052", er, rd); end
    txn(1'b0, 9'h010, $urandom, rd, er, lat, nwr, nrd, nba);
    n_cmp++; if (er !== 1'b0 || rd !== 32'h00000053) begin n_bad++; $display("FAIL wv_read_after: got err=%b rdata=%h want 0/00000053", er, rd); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [DW-1:0] rd, d; logic er; int lat, nwr, nrd, nba, a, ra;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 511); d = $urandom;
      txn(1'b1, AW'(a), d, rd, er, lat, nwr, nrd, nba);
      ref_mem[a] = d; written.push_back(a);
      n_cmp++; if (lat != WR_LAT || nwr != 1 || nba != 0 || er !== 1'b0) begin n_bad++; $display("FAIL b2b_write %0d: got lat=%0d wr=%0d bad=%0d err=%b want %0d/1/0/0", i, lat, nwr, nba, er, WR_LAT); end
      ra = (i % 2 == 0) ? a : written[$urandom_range(0, written.size() - 1)];
      txn(1'b0, AW'(ra), $urandom, rd, er, lat, nwr, nrd, nba);
      n_cmp++; if (rd !== ref_mem[ra] || lat != RD_LAT || nwr != 0) begin n_bad++; $display("FAIL b2b_read %0d: got %h lat=%0d wr=%0d want %h lat=%0d wr=0", i, rd, lat, nwr, ref_mem[ra], RD_LAT); end
    end
    n_cmp++; if (both_hi != 0) begin n_bad++; $display("FAIL strobe_exclusive: got %0d overlap cycles want 0", both_hi); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_write_read();
    test_backpressure();
    test_reset_mid();
`ifdef MEM_CTRL_WRVERIFY_EN
    test_write_verify();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
